// File: rtl/cv_ctrl_ports.sv
// ColecoVision controller-port engine: turns MiSTer joystick words into active-low
// port pins selected by p5/p8, with a keypad settling filter and a spinner quadrature generator.
`timescale 1ns/1ps
module cv_ctrl_ports #(
  parameter int NUM_PORTS = 2,
  parameter int KEY_HOLD  = 3,
  parameter int SPIN_DIV  = 4096
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    clk_en_i,
  input  logic [20*NUM_PORTS-1:0] joy_i,
  input  logic [8*NUM_PORTS-1:0]  spin_i,
  input  logic [NUM_PORTS-1:0]    spin_en_i,
  input  logic [NUM_PORTS-1:0]    ctrl_p5_i,
  input  logic [NUM_PORTS-1:0]    ctrl_p8_i,
  output logic [NUM_PORTS-1:0]    ctrl_p1_o,
  output logic [NUM_PORTS-1:0]    ctrl_p2_o,
  output logic [NUM_PORTS-1:0]    ctrl_p3_o,
  output logic [NUM_PORTS-1:0]    ctrl_p4_o,
  output logic [NUM_PORTS-1:0]    ctrl_p6_o,
  output logic [NUM_PORTS-1:0]    ctrl_p7_o,
  output logic [NUM_PORTS-1:0]    ctrl_p9_o
);

  localparam logic [3:0] HOLD = 4'(KEY_HOLD);
  localparam int ACC_W = $clog2(SPIN_DIV) + 1;
  localparam int SUM_W = ((ACC_W > 8) ? ACC_W : 8) + 1;
  localparam logic [SUM_W-1:0] DIV_S = SUM_W'(SPIN_DIV);

  function automatic logic [3:0] key_code(input logic [19:0] j);
    logic [3:0] c;
    if      (j[8])  c = 4'b0011;
    else if (j[9])  c = 4'b1110;
    else if (j[10]) c = 4'b1101;
    else if (j[11]) c = 4'b0110;
    else if (j[12]) c = 4'b0001;
    else if (j[13]) c = 4'b1001;
    else if (j[14]) c = 4'b0111;
    else if (j[15]) c = 4'b1100;
    else if (j[16]) c = 4'b1000;
    else if (j[17]) c = 4'b1011;
    else if (j[6])  c = 4'b1010;
    else if (j[7])  c = 4'b0101;
    else if (j[18]) c = 4'b0100;
    else if (j[19]) c = 4'b0010;
    else            c = 4'b1111;
    return c;
  endfunction

  // Forward walks 11->10->00->01->11, reverse walks the opposite way.
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic neg);
    logic [1:0] n;
    case (ph)
      2'b11:   n = neg ? 2'b01 : 2'b10;
      2'b10:   n = neg ? 2'b11 : 2'b00;
      2'b00:   n = neg ? 2'b10 : 2'b01;
      2'b01:   n = neg ? 2'b00 : 2'b11;
      default: n = 2'b11;
    endcase
    return n;
  endfunction

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [19:0]      joy_s;
    logic [7:0]       spin_s;
    logic [7:0]       neg_s;
    logic [6:0]       mag_s;
    logic [3:0]       raw_s;
    logic [3:0]       cnt_nxt_s;
    logic [3:0]       cand_r;
    logic [3:0]       stable_r;
    logic [3:0]       cnt_r;
    logic [5:0]       joy_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [SUM_W-1:0] sum_s;
    logic [SUM_W-1:0] rem_s;
    logic             step_s;
    logic [1:0]       phase_r;
    logic [3:0]       key_s;
    logic [3:0]       jst_s;
    logic [3:0]       pins_s;
    logic             fire_s;

    assign joy_s  = joy_i[g*20 +: 20];
    assign spin_s = spin_i[g*8 +: 8];
    assign raw_s  = key_code(joy_s);
    assign neg_s  = 8'd0 - spin_s;

    // Settling counter and spinner accumulator next-state.
    always_comb begin
      cnt_nxt_s = cnt_r;
      mag_s     = 7'd0;
      acc_nxt_s = acc_r;
      if (raw_s != cand_r) begin
        cnt_nxt_s = 4'd1;
      end else if (cnt_r < HOLD) begin
        cnt_nxt_s = cnt_r + 4'd1;
      end else begin
        cnt_nxt_s = cnt_r;
      end
      if (spin_s == 8'h80) begin
        mag_s = 7'd127;
      end else if (spin_s[7]) begin
        mag_s = neg_s[6:0];
      end else begin
        mag_s = spin_s[6:0];
      end
      sum_s  = SUM_W'(acc_r) + SUM_W'(mag_s);
      rem_s  = sum_s - DIV_S;
      step_s = (sum_s >= DIV_S);
      // Only one step per tick; any excess beyond a second step is dropped.
      if (!step_s) begin
        acc_nxt_s = ACC_W'(sum_s);
      end else if (rem_s >= DIV_S) begin
        acc_nxt_s = ACC_W'(SPIN_DIV - 1);
      end else begin
        acc_nxt_s = ACC_W'(rem_s);
      end
    end

    // Keypad filter and joystick sample registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cand_r   <= 4'b1111;
        stable_r <= 4'b1111;
        cnt_r    <= 4'd0;
        joy_r    <= 6'd0;
      end else if (clk_en_i) begin
        cand_r <= raw_s;
        cnt_r  <= cnt_nxt_s;
        joy_r  <= joy_s[5:0];
        if (cnt_nxt_s == HOLD) begin
          stable_r <= raw_s;
        end
      end
    end

    // Spinner accumulator and quadrature phase.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        acc_r   <= '0;
        phase_r <= 2'b11;
      end else if (clk_en_i) begin
        if (!spin_en_i[g]) begin
          acc_r   <= '0;
          phase_r <= 2'b11;
        end else begin
          acc_r <= acc_nxt_s;
          if (step_s) begin
            phase_r <= next_phase(phase_r, spin_s[7]);
          end
        end
      end
    end

    // Select-driven pin combination; selects reach the pins with no register delay.
    always_comb begin
      key_s  = ~ctrl_p5_i[g] ? stable_r : 4'b1111;
      jst_s  = ~ctrl_p8_i[g] ? {~joy_r[3], ~joy_r[2], ~joy_r[1], ~joy_r[0]} : 4'b1111;
      pins_s = key_s & jst_s;
      fire_s = (~ctrl_p5_i[g] ? ~joy_r[5] : 1'b1) & (~ctrl_p8_i[g] ? ~joy_r[4] : 1'b1);
    end

    assign ctrl_p1_o[g] = pins_s[3];
    assign ctrl_p2_o[g] = pins_s[2];
    assign ctrl_p3_o[g] = pins_s[1];
    assign ctrl_p4_o[g] = pins_s[0];
    assign ctrl_p6_o[g] = fire_s;
    assign ctrl_p7_o[g] = phase_r[1];
    assign ctrl_p9_o[g] = phase_r[0];
  end

endmodule

// File: tb/tb_cv_ctrl_ports.sv
// Directed self-checking bench for cv_ctrl_ports (4 ports, KEY_HOLD=3, SPIN_DIV=16).
`timescale 1ns/1ps
module tb_cv_ctrl_ports;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic reset_n, clk_en;
  logic [20*NP-1:0] joy;
  logic [8*NP-1:0]  spin;
  logic [NP-1:0]    spin_en, p5, p8;
  logic [NP-1:0]    p1, p2, p3, p4, p6, p7, p9;
  int checks = 0;
  int errors = 0;

  logic [1:0] exp_pos [8] = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
  logic [1:0] exp_neg [8] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
  logic [1:0] exp_max [3] = '{2'b01, 2'b00, 2'b10};

  always #5 clk = ~clk;

  cv_ctrl_ports #(.NUM_PORTS(NP), .KEY_HOLD(3), .SPIN_DIV(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clk_en_i(clk_en),
    .joy_i(joy), .spin_i(spin), .spin_en_i(spin_en),
    .ctrl_p5_i(p5), .ctrl_p8_i(p8),
    .ctrl_p1_o(p1), .ctrl_p2_o(p2), .ctrl_p3_o(p3), .ctrl_p4_o(p4),
    .ctrl_p6_o(p6), .ctrl_p7_o(p7), .ctrl_p9_o(p9)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pins(input int p);
    return {4'b0000, p1[p], p2[p], p3[p], p4[p]};
  endfunction

  function automatic logic [7:0] phase(input int p);
    return {6'b000000, p7[p], p9[p]};
  endfunction

  function automatic logic [19:0] key(input int b);
    logic [19:0] one;
    one = 20'd1;
    return one << b;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_joy(input int p, input logic [19:0] v);
    joy[p*20 +: 20] = v;
  endtask

  task automatic set_spin(input int p, input logic [7:0] v);
    spin[p*8 +: 8] = v;
  endtask

  initial begin
    // Reset with everything active.
    reset_n = 1'b0; clk_en = 1'b1; p5 = '0; p8 = '0; spin_en = '1;
    for (int p = 0; p < NP; p++) begin
      set_joy(p, key(13) | key(3) | key(4));
      set_spin(p, 8'd8);
    end
    tick(3);
    check_eq("rst_pins", pins(0), 8'b1111);
    check_eq("rst_p6", {7'd0, p6[0]}, 8'd1);
    check_eq("rst_phase", phase(0), 8'b11);
    clk_en = 1'b0; reset_n = 1'b1;
    tick(2);
    check_eq("rel_pins", pins(0), 8'b1111);
    check_eq("rel_p6", {7'd0, p6[0]}, 8'd1);
    check_eq("rel_phase", phase(0), 8'b11);
    reset_n = 1'b0; joy = '0; spin = '0; spin_en = '0; p5 = '1; p8 = '1; clk_en = 1'b1;
    tick(1);
    reset_n = 1'b1;
    tick(4);

    // Keypad settling on port 0.
    p5[0] = 1'b0;
    set_joy(0, key(13));
    tick(1); check_eq("key5_t1", pins(0), 8'b1111);
    tick(1); check_eq("key5_t2", pins(0), 8'b1111);
    tick(1); check_eq("key5_t3", pins(0), 8'b1001);
    clk_en = 1'b0;
    set_joy(0, key(11) | key(15));
    tick(4); check_eq("ce_gate", pins(0), 8'b1001);
    clk_en = 1'b1;
    tick(2); check_eq("key37_t2", pins(0), 8'b1001);
    tick(1); check_eq("key37_t3", pins(0), 8'b0110);
    p5[0] = 1'b1; #1 check_eq("p5_high", pins(0), 8'b1111);
    p5[0] = 1'b0; #1 check_eq("p5_low", pins(0), 8'b0110);
    set_joy(0, 20'd0);
    tick(3); check_eq("key_rel", pins(0), 8'b1111);
    set_joy(0, key(16));
    tick(2);
    set_joy(0, 20'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1); check_eq("glitch", pins(0), 8'b1111);
    end
    p5[0] = 1'b1;

    // Joystick on port 1.
    p8[1] = 1'b0;
    set_joy(1, key(3) | key(4));
    #1 check_eq("joy_pre", pins(1), 8'b1111);
    tick(1);
    check_eq("joy_up", pins(1), 8'b0111);
    check_eq("joy_f1", {7'd0, p6[1]}, 8'd0);
    p5[1] = 1'b0;
    set_joy(1, key(9) | key(0));
    tick(3);
    check_eq("both_sel", pins(1), 8'b1110);
    check_eq("both_nofire", {7'd0, p6[1]}, 8'd1);
    set_joy(1, key(9) | key(0) | key(5));
    tick(1); check_eq("fire2_p5", {7'd0, p6[1]}, 8'd0);
    p5[1] = 1'b1;
    #1 check_eq("fire2_p8only", {7'd0, p6[1]}, 8'd1);
    check_eq("joy_r_only", pins(1), 8'b1110);
    set_joy(1, key(4));
    tick(1); check_eq("fire1_p8", {7'd0, p6[1]}, 8'd0);
    p8[1] = 1'b1; set_joy(1, 20'd0);

    // Spinner on port 2.
    spin_en[2] = 1'b1; set_spin(2, 8'd8);
    for (int i = 0; i < 8; i++) begin
      tick(1); check_eq("spin_pos", phase(2), {6'd0, exp_pos[i]});
    end
    set_spin(2, 8'hF8);
    for (int i = 0; i < 8; i++) begin
      tick(1); check_eq("spin_neg", phase(2), {6'd0, exp_neg[i]});
    end
    set_spin(2, 8'd8);
    tick(4); check_eq("spin_mid", phase(2), 8'b00);
    tick(1);
    spin_en[2] = 1'b0;
    tick(1); check_eq("spin_dis", phase(2), 8'b11);
    spin_en[2] = 1'b1; set_spin(2, 8'd16);
    tick(1); check_eq("spin_reen1", phase(2), 8'b10);
    tick(1); check_eq("spin_reen2", phase(2), 8'b00);
    spin_en[2] = 1'b0;
    tick(1);
    spin_en[2] = 1'b1; set_spin(2, 8'h80);
    for (int i = 0; i < 3; i++) begin
      tick(1); check_eq("spin_max", phase(2), {6'd0, exp_max[i]});
    end
    set_spin(2, 8'd0);
    tick(2); check_eq("spin_zero", phase(2), 8'b10);
    spin_en[2] = 1'b0;
    tick(1);

    // Four ports, independent keys.
    p5 = '0; p8 = '1;
    set_joy(0, key(8)); set_joy(1, key(17)); set_joy(2, key(6)); set_joy(3, key(19));
    tick(3);
    check_eq("port0_k0", pins(0), 8'b0011);
    check_eq("port1_k9", pins(1), 8'b1011);
    check_eq("port2_star", pins(2), 8'b1010);
    check_eq("port3_blue", pins(3), 8'b0010);
    check_eq("port0_phase", phase(0), 8'b11);

    // Asynchronous reset mid-operation.
    reset_n = 1'b0;
    #1 check_eq("async_rst", pins(1), 8'b1111);
    check_eq("async_rst_p3", pins(3), 8'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
